edge_frame_streamer: RTL

Host-side streaming engine for the edge-detection filter. On a go command it pulses the filter's start, reads the input image byte-by-byte from memory over an Avalon-MM master port and writes each pixel into the filter. It then captures the filter's output burst into an internal result buffer and writes that buffer back to memory through the same master port. It sits between the system interconnect and the edge-detector datapath/controller pair.

---
 rtl/edge_frame_streamer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/edge_frame_streamer.sv
// Host-side streaming engine for the edge-detection filter: fetches an image over an
// Avalon-MM master, feeds it to the filter, buffers the result burst and writes it back.
module edge_frame_streamer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int IN_PIXELS  = 64,
  parameter int OUT_PIXELS = 36
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] srcBase_i,
  input  logic [ADDR_W-1:0] dstBase_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] avmAddress_o,
  output logic              avmRead_o,
  output logic              avmWrite_o,
  output logic [DATA_W-1:0] avmWritedata_o,
  input  logic [DATA_W-1:0] avmReaddata_i,
  input  logic              avmWaitrequest_i,
  input  logic              avmReaddatavalid_i,
  output logic              edStart_o,
  output logic [DATA_W-1:0] edPix_o,
  output logic              edPixWr_o,
  input  logic              edDataAvailable_i,
  input  logic [DATA_W-1:0] edRes_i
);

  localparam int MAX_PIX = (IN_PIXELS > OUT_PIXELS) ? IN_PIXELS : OUT_PIXELS;
  localparam int CNT_W   = $clog2(MAX_PIX + 1);
  localparam int BUF_AW  = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_RD_REQ,
    S_RD_WAIT,
    S_PUSH,
    S_WAIT_RES,
    S_CAPTURE,
    S_WR,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [DATA_W-1:0]   pix_q, pix_d;

  logic                buf_we;
  logic [BUF_AW-1:0]   buf_waddr;
  logic [DATA_W-1:0]   res_buf [OUT_PIXELS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      wr_cnt_q  <= '0;
      pix_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_cnt_q  <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      pix_q     <= pix_d;
    end
  end

  // NOTE: the result buffer is a plain memory with no reset; its contents are
  // always rewritten by a capture before they are read back out.
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      res_buf[buf_waddr] <= edRes_i;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_cnt_d  = rd_cnt_q;
    cap_cnt_d = cap_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    pix_d     = pix_q;
    buf_we    = 1'b0;
    buf_waddr = cap_cnt_q[BUF_AW-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          src_d     = srcBase_i;
          dst_d     = dstBase_i;
          rd_cnt_d  = '0;
          cap_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_RD_REQ;
      S_RD_REQ: begin
        if (!avmWaitrequest_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Only one read is ever outstanding, so the next valid beat is ours.
        if (avmReaddatavalid_i) begin
          pix_d   = avmReaddata_i;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        state_d  = (rd_cnt_d == CNT_W'(IN_PIXELS)) ? S_WAIT_RES : S_RD_REQ;
      end
      S_WAIT_RES: begin
        if (edDataAvailable_i) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          cap_cnt_d = CNT_W'(1);
          state_d   = (cap_cnt_d == CNT_W'(OUT_PIXELS)) ? S_WR : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Gaps in the burst simply pause the capture; the index only advances on data.
        if (edDataAvailable_i) begin
          buf_we    = 1'b1;
          cap_cnt_d = cap_cnt_q + CNT_W'(1);
          if (cap_cnt_d == CNT_W'(OUT_PIXELS)) state_d = S_WR;
        end
      end
      S_WR: begin
        if (!avmWaitrequest_i) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (wr_cnt_d == CNT_W'(OUT_PIXELS)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so nothing combinational reaches
  // them from an input and reset forces them all low immediately.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    avmRead_o      = (state_q == S_RD_REQ);
    avmWrite_o     = (state_q == S_WR);
    edStart_o      = (state_q == S_START);
    edPixWr_o      = (state_q == S_PUSH);
    avmAddress_o   = '0;
    avmWritedata_o = '0;
    edPix_o        = '0;
    if (state_q == S_RD_REQ) avmAddress_o = src_q + ADDR_W'(rd_cnt_q);
    if (state_q == S_WR) begin
      avmAddress_o   = dst_q + ADDR_W'(wr_cnt_q);
      avmWritedata_o = res_buf[wr_cnt_q[BUF_AW-1:0]];
    end
    if (state_q == S_PUSH) edPix_o = pix_q;
  end

endmodule
